// File: rtl/game_pkg.sv
// Shared types and constants for the game-flow controller.
package game_pkg;

  localparam int LIVES_W = 4;
  localparam int ENEMY_W = 6;

  typedef enum logic [2:0] {
    MENU,
    START,
    PLAYING,
    CONTINUE,
    FINAL,
    PAUSED
  } game_state_e;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Button, gameplay-event and screen/status signals of the game-flow controller.
interface game_ctrl_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 11
);
  import game_pkg::*;

  localparam int NP_W = $clog2(NUM_PLAYERS + 1);

  logic                           frame_tick_i;
  logic                           fire_i;
  logic                           sel_up_i;
  logic                           sel_down_i;
  logic                           pause_i;
  logic [NUM_PLAYERS-1:0]         player_die_i;
  logic [NUM_PLAYERS-1:0]         enemy_kill_i;
  logic                           eagle_hit_i;

  logic                           is_menu_o;
  logic                           is_playing_o;
  logic                           is_continue_o;
  logic                           is_final_o;
  logic                           is_paused_o;
  logic                           round_reset_o;
  logic [NP_W-1:0]                num_players_o;
  logic [NUM_PLAYERS-1:0]         active_o;
  logic [LIVES_W*NUM_PLAYERS-1:0] lives_o;
  logic [SCORE_W*NUM_PLAYERS-1:0] score_o;
  logic [ENEMY_W-1:0]             enemy_left_o;
  logic [3:0]                     level_o;
  logic                           win_o;

  modport slave (
    input  frame_tick_i, fire_i, sel_up_i, sel_down_i, pause_i,
           player_die_i, enemy_kill_i, eagle_hit_i,
    output is_menu_o, is_playing_o, is_continue_o, is_final_o, is_paused_o,
           round_reset_o, num_players_o, active_o, lives_o, score_o,
           enemy_left_o, level_o, win_o
  );

  modport master (
    output frame_tick_i, fire_i, sel_up_i, sel_down_i, pause_i,
           player_die_i, enemy_kill_i, eagle_hit_i,
    input  is_menu_o, is_playing_o, is_continue_o, is_final_o, is_paused_o,
           round_reset_o, num_players_o, active_o, lives_o, score_o,
           enemy_left_o, level_o, win_o
  );

endinterface

// File: rtl/game_ctrl_btn_edge.sv
// Registered rising-edge detector for a level-sensitive button input.
module btn_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prev_q <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      prev_q <= btn_i;
      rise_o <= btn_i & ~prev_q;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow controller: player select, rounds, lives/score, levels and final screen.
// Optional pause screen is built when GAME_CTRL_PAUSE_EN is defined.
module game_ctrl
  import game_pkg::*;
#(
  parameter int NUM_PLAYERS       = 2,
  parameter int LIVES_INIT        = 4,
  parameter int ENEMIES_PER_LEVEL = 20,
  parameter int NUM_LEVELS        = 8,
  parameter int SCORE_W           = 11,
  parameter int FINAL_FRAMES      = 180
) (
  input  logic       clk_i,
  input  logic       reset_i,
  game_ctrl_if.slave bus
);

  localparam int NP_W = $clog2(NUM_PLAYERS + 1);
  localparam int FC_W = $clog2(FINAL_FRAMES + 1);

  game_state_e                         state_q, state_d;
  logic [NP_W-1:0]                     num_q, num_d;
  logic [NUM_PLAYERS-1:0][LIVES_W-1:0] lives_q, lives_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q, score_d;
  logic [ENEMY_W-1:0]                  enemy_q, enemy_d, kills;
  logic [3:0]                          level_q, level_d;
  logic                                win_q, win_d;
  logic [FC_W-1:0]                     frame_q, frame_d;
  logic [NUM_PLAYERS-1:0]              active_d;
  logic                                any_alive;
  logic                                fire_rise, up_rise, down_rise, pause_rise;

  btn_edge u_fire (.clk_i, .reset_i, .btn_i(bus.fire_i),     .rise_o(fire_rise));
  btn_edge u_up   (.clk_i, .reset_i, .btn_i(bus.sel_up_i),   .rise_o(up_rise));
  btn_edge u_down (.clk_i, .reset_i, .btn_i(bus.sel_down_i), .rise_o(down_rise));

`ifdef GAME_CTRL_PAUSE_EN
  btn_edge u_pause (.clk_i, .reset_i, .btn_i(bus.pause_i), .rise_o(pause_rise));
`else
  assign pause_rise      = 1'b0;
  assign bus.is_paused_o = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    lives_d   = lives_q;
    score_d   = score_q;
    enemy_d   = enemy_q;
    level_d   = level_q;
    win_d     = win_q;
    frame_d   = frame_q;
    any_alive = 1'b0;
    kills     = ENEMY_W'(popcount(32'(bus.enemy_kill_i)));

    case (state_q)
      MENU: begin
        if (up_rise && num_q != NP_W'(NUM_PLAYERS)) begin
          num_d = num_q + NP_W'(1);
        end else if (down_rise && num_q != NP_W'(1)) begin
          num_d = num_q - NP_W'(1);
        end
        // A new game loads everything up front so the round-reset cycle already shows it.
        if (fire_rise) begin
          state_d = START;
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            lives_d[i] = (i < int'(num_d)) ? LIVES_W'(LIVES_INIT) : '0;
          end
          score_d = '0;
          level_d = '0;
          win_d   = 1'b0;
          enemy_d = ENEMY_W'(ENEMIES_PER_LEVEL);
        end
      end

      START: state_d = PLAYING;

      PLAYING: begin
        if (pause_rise) begin
          state_d = PAUSED;
        end else begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (bus.player_die_i[i] && lives_q[i] != '0) lives_d[i] = lives_q[i] - LIVES_W'(1);
            if (bus.enemy_kill_i[i] && score_q[i] != '1) score_d[i] = score_q[i] + SCORE_W'(1);
            if (lives_d[i] != '0) any_alive = 1'b1;
          end
          enemy_d = (kills >= enemy_q) ? '0 : enemy_q - kills;
          // Game over outranks a level clear landing in the same cycle.
          if (bus.eagle_hit_i || !any_alive) begin
            state_d = FINAL;
            win_d   = 1'b0;
            frame_d = '0;
          end else if (enemy_d == '0 && level_q == 4'(NUM_LEVELS - 1)) begin
            state_d = FINAL;
            win_d   = 1'b1;
            frame_d = '0;
          end else if (enemy_d == '0) begin
            state_d = CONTINUE;
          end
        end
      end

      CONTINUE: begin
        if (fire_rise) begin
          state_d = START;
          level_d = level_q + 4'd1;
          enemy_d = ENEMY_W'(ENEMIES_PER_LEVEL);
        end
      end

      FINAL: begin
        if (fire_rise) begin
          state_d = MENU;
        end else if (bus.frame_tick_i) begin
          if (frame_q == FC_W'(FINAL_FRAMES - 1)) state_d = MENU;
          else                                    frame_d = frame_q + FC_W'(1);
        end
      end

      PAUSED: begin
        if (pause_rise) state_d = PLAYING;
      end

      default: state_d = MENU;
    endcase

    for (int i = 0; i < NUM_PLAYERS; i++) active_d[i] = (lives_d[i] != '0);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q           <= MENU;
      num_q             <= NP_W'(1);
      lives_q           <= '0;
      score_q           <= '0;
      enemy_q           <= ENEMY_W'(ENEMIES_PER_LEVEL);
      level_q           <= '0;
      win_q             <= 1'b0;
      frame_q           <= '0;
      bus.is_menu_o     <= 1'b1;
      bus.is_playing_o  <= 1'b0;
      bus.is_continue_o <= 1'b0;
      bus.is_final_o    <= 1'b0;
      bus.round_reset_o <= 1'b0;
      bus.active_o      <= '0;
      bus.win_o         <= 1'b0;
`ifdef GAME_CTRL_PAUSE_EN
      bus.is_paused_o   <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      num_q             <= num_d;
      lives_q           <= lives_d;
      score_q           <= score_d;
      enemy_q           <= enemy_d;
      level_q           <= level_d;
      win_q             <= win_d;
      frame_q           <= frame_d;
      bus.is_menu_o     <= (state_d == MENU);
      bus.is_playing_o  <= (state_d == PLAYING);
      bus.is_continue_o <= (state_d == CONTINUE);
      bus.is_final_o    <= (state_d == FINAL);
      bus.round_reset_o <= (state_d == START);
      bus.active_o      <= active_d;
      bus.win_o         <= win_d && (state_d == FINAL);
`ifdef GAME_CTRL_PAUSE_EN
      bus.is_paused_o   <= (state_d == PAUSED);
`endif
    end
  end

  assign bus.num_players_o = num_q;
  assign bus.lives_o       = lives_q;
  assign bus.score_o       = score_q;
  assign bus.enemy_left_o  = enemy_q;
  assign bus.level_o       = level_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed flow plus randomized play against a rules model.
module tb_game_ctrl;
  import game_pkg::*;

  localparam int NP     = 2;
  localparam int SW     = 11;
  localparam int LIVES  = 4;
  localparam int ENEM   = 20;
  localparam int LEVELS = 8;
  localparam int SMAX   = (1 << SW) - 1;

  typedef enum {P_MENU, P_PLAY, P_CONT, P_FINAL, P_PAUSE} phase_e;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  game_ctrl_if #(.NUM_PLAYERS(NP), .SCORE_W(SW)) g ();
  game_ctrl_if #(.NUM_PLAYERS(NP), .SCORE_W(SW)) h ();

  game_ctrl #(.NUM_PLAYERS(NP), .SCORE_W(SW)) dut (
    .clk_i(clk), .reset_i(reset), .bus(g.slave)
  );

  game_ctrl #(.NUM_PLAYERS(NP), .NUM_LEVELS(1), .ENEMIES_PER_LEVEL(3), .SCORE_W(SW)) dut_one (
    .clk_i(clk), .reset_i(reset), .bus(h.slave)
  );

  int errors = 0;
  int checks = 0;

  // Rules model of the main instance.
  phase_e m_phase;
  int     m_num;
  int     m_lives[NP];
  int     m_score[NP];
  int     m_enemy;
  int     m_level;
  bit     m_win;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_MENU;
    m_num   = 1;
    m_enemy = ENEM;
    m_level = 0;
    m_win   = 1'b0;
    for (int i = 0; i < NP; i++) begin
      m_lives[i] = 0;
      m_score[i] = 0;
    end
  endtask

  task automatic model_apply(input logic [NP-1:0] kill, input logic [NP-1:0] die, input logic eagle);
    int alive;
    if (m_phase != P_PLAY) return;
    alive = 0;
    for (int i = 0; i < NP; i++) begin
      if (die[i] && m_lives[i] > 0) m_lives[i]--;
      if (kill[i] && m_score[i] < SMAX) m_score[i]++;
      alive += m_lives[i];
    end
    m_enemy -= $countones(kill);
    if (m_enemy < 0) m_enemy = 0;
    if (eagle || alive == 0) begin
      m_phase = P_FINAL;
      m_win   = 1'b0;
    end else if (m_enemy == 0 && m_level == LEVELS - 1) begin
      m_phase = P_FINAL;
      m_win   = 1'b1;
    end else if (m_enemy == 0) begin
      m_phase = P_CONT;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [4*NP-1:0]  el;
    logic [SW*NP-1:0] es;
    logic [NP-1:0]    ea;
    for (int i = 0; i < NP; i++) begin
      el[4*i +: 4]   = 4'(m_lives[i]);
      es[SW*i +: SW] = SW'(m_score[i]);
      ea[i]          = (m_lives[i] > 0);
    end
    check({tag, ".lives"},    64'(g.lives_o),       64'(el));
    check({tag, ".score"},    64'(g.score_o),       64'(es));
    check({tag, ".active"},   64'(g.active_o),      64'(ea));
    check({tag, ".enemy"},    64'(g.enemy_left_o),  64'(m_enemy));
    check({tag, ".level"},    64'(g.level_o),       64'(m_level));
    check({tag, ".num"},      64'(g.num_players_o), 64'(m_num));
    check({tag, ".menu"},     64'(g.is_menu_o),     64'(m_phase == P_MENU));
    check({tag, ".playing"},  64'(g.is_playing_o),  64'(m_phase == P_PLAY));
    check({tag, ".continue"}, 64'(g.is_continue_o), 64'(m_phase == P_CONT));
    check({tag, ".final"},    64'(g.is_final_o),    64'(m_phase == P_FINAL));
    check({tag, ".paused"},   64'(g.is_paused_o),   64'(m_phase == P_PAUSE));
    check({tag, ".win"},      64'(g.win_o),         64'(m_phase == P_FINAL && m_win));
    check({tag, ".rreset"},   64'(g.round_reset_o), 64'(0));
  endtask

  // One gameplay cycle on the main instance: drive, clock, update model, compare.
  task automatic cycle(input logic [NP-1:0] kill, input logic [NP-1:0] die, input logic eagle,
                       input string tag);
    g.enemy_kill_i = kill;
    g.player_die_i = die;
    g.eagle_hit_i  = eagle;
    @(negedge clk);
    g.enemy_kill_i = '0;
    g.player_die_i = '0;
    g.eagle_hit_i  = 1'b0;
    model_apply(kill, die, eagle);
    check_outputs(tag);
  endtask

  task automatic press(input int which);
    case (which)
      0: g.sel_up_i   = 1'b1;
      1: g.sel_down_i = 1'b1;
      default: g.pause_i = 1'b1;
    endcase
    @(negedge clk);
    g.sel_up_i   = 1'b0;
    g.sel_down_i = 1'b0;
    g.pause_i    = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_game(input bit from_menu, input string tag);
    g.fire_i = 1'b1;
    @(negedge clk);
    g.fire_i = 1'b0;
    check({tag, ".rr_early"}, 64'(g.round_reset_o), 64'(0));
    @(negedge clk);
    check({tag, ".rr_pulse"}, 64'(g.round_reset_o), 64'(1));
    check({tag, ".rr_notplay"}, 64'(g.is_playing_o), 64'(0));
    if (from_menu) begin
      for (int i = 0; i < NP; i++) begin
        m_lives[i] = (i < m_num) ? LIVES : 0;
        m_score[i] = 0;
      end
      m_level = 0;
      m_win   = 1'b0;
    end else begin
      m_level++;
    end
    m_enemy = ENEM;
    @(negedge clk);
    m_phase = P_PLAY;
    check_outputs({tag, ".play"});
  endtask

  initial begin
    logic [NP-1:0] kill, die;

    g.frame_tick_i = 1'b0; g.fire_i = 1'b0; g.sel_up_i = 1'b0; g.sel_down_i = 1'b0;
    g.pause_i = 1'b0; g.player_die_i = '0; g.enemy_kill_i = '0; g.eagle_hit_i = 1'b0;
    h.frame_tick_i = 1'b0; h.fire_i = 1'b0; h.sel_up_i = 1'b0; h.sel_down_i = 1'b0;
    h.pause_i = 1'b0; h.player_die_i = '0; h.enemy_kill_i = '0; h.eagle_hit_i = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_outputs("idle");

    // Player count saturates at NUM_PLAYERS.
    for (int n = 0; n < 3; n++) begin
      press(0);
      m_num = (m_num < NP) ? m_num + 1 : NP;
    end
    check("sel_up_sat", 64'(g.num_players_o), 64'(2));

    start_game(1'b1, "start2p");
    check("start_lives", 64'(g.lives_o), 64'(8'h44));
    check("start_enemy", 64'(g.enemy_left_o), 64'(20));

    cycle(2'b11, 2'b00, 1'b0, "kill11");
    check("kill11_enemy", 64'(g.enemy_left_o), 64'(18));
    check("kill11_score", 64'(g.score_o), {42'd0, 11'd1, 11'd1});

    // Randomized level-0 play; deaths never take a player to zero here.
    for (int n = 0; n < 300 && m_phase == P_PLAY; n++) begin
      kill = NP'($urandom_range(0, 3));
      die  = '0;
      for (int i = 0; i < NP; i++) begin
        if ($urandom_range(0, 15) == 0 && m_lives[i] > 1) die[i] = 1'b1;
      end
      cycle(kill, die, 1'b0, "rand_l0");
    end
    check("l0_continue", 64'(g.is_continue_o), 64'(1));

    start_game(1'b0, "next_level");
    check("l1_level", 64'(g.level_o), 64'(1));

`ifdef GAME_CTRL_PAUSE_EN
    press(2);
    m_phase = P_PAUSE;
    check_outputs("pause_on");
    cycle(2'b11, 2'b00, 1'b0, "pause_kill");
    press(2);
    m_phase = P_PLAY;
    check_outputs("pause_off");
    check("pause_off_playing", 64'(g.is_playing_o), 64'(1));
`else
    press(2);
    check_outputs("pause_unused");
`endif

    // Last kill together with the eagle hit: game over wins over level clear.
    for (int n = 0; n < 40 && m_enemy > 1; n++) cycle(2'b01, 2'b00, 1'b0, "l1_kill");
    cycle(2'b01, 2'b00, 1'b1, "kill_eagle");
    check("eagle_final", 64'(g.is_final_o), 64'(1));
    check("eagle_nowin", 64'(g.win_o), 64'(0));
    check("eagle_enemy0", 64'(g.enemy_left_o), 64'(0));

    // Final screen times out on the 180th frame tick.
    g.frame_tick_i = 1'b1;
    repeat (179) @(negedge clk);
    check("final_hold_179", 64'(g.is_final_o), 64'(1));
    @(negedge clk);
    g.frame_tick_i = 1'b0;
    m_phase = P_MENU;
    check_outputs("final_timeout");

    cycle(2'b11, 2'b11, 1'b1, "menu_ignore");

    for (int n = 0; n < 2; n++) begin
      press(1);
      m_num = (m_num > 1) ? m_num - 1 : 1;
    end
    check("sel_down_sat", 64'(g.num_players_o), 64'(1));

    start_game(1'b1, "start1p");
    check("start1p_lives", 64'(g.lives_o), 64'(8'h04));
    check("start1p_active", 64'(g.active_o), 64'(2'b01));

    for (int n = 0; n < 4; n++) cycle(2'b00, 2'b01, 1'b0, "p0_die");
    check("die_final", 64'(g.is_final_o), 64'(1));
    check("die_nowin", 64'(g.win_o), 64'(0));
    check("die_inactive", 64'(g.active_o), 64'(0));

    // Fire leaves the final screen early.
    g.fire_i = 1'b1;
    @(negedge clk);
    g.fire_i = 1'b0;
    check("fire_exit_wait", 64'(g.is_final_o), 64'(1));
    @(negedge clk);
    m_phase = P_MENU;
    check_outputs("fire_exit");

    // Single-level instance: clearing its only level is a win; enemy count floors at zero.
    h.fire_i = 1'b1;
    @(negedge clk);
    h.fire_i = 1'b0;
    @(negedge clk);
    check("one_rr", 64'(h.round_reset_o), 64'(1));
    @(negedge clk);
    check("one_playing", 64'(h.is_playing_o), 64'(1));
    check("one_enemy3", 64'(h.enemy_left_o), 64'(3));
    for (int n = 0; n < 2; n++) begin
      h.enemy_kill_i = 2'b01;
      @(negedge clk);
      h.enemy_kill_i = 2'b00;
    end
    check("one_enemy1", 64'(h.enemy_left_o), 64'(1));
    h.enemy_kill_i = 2'b11;
    @(negedge clk);
    h.enemy_kill_i = 2'b00;
    check("one_enemy0", 64'(h.enemy_left_o), 64'(0));
    check("one_final", 64'(h.is_final_o), 64'(1));
    check("one_win", 64'(h.win_o), 64'(1));
    check("one_level", 64'(h.level_o), 64'(0));
    check("one_score0", 64'(h.score_o[SW-1:0]), 64'(3));

    // Mid-game reset goes straight to the menu with no round reset.
    start_game(1'b1, "restart");
    cycle(2'b01, 2'b00, 1'b0, "restart_kill");
    reset = 1'b1;
    @(negedge clk);
    model_reset();
    check_outputs("midreset");
    reset = 1'b0;
    @(negedge clk);
    check_outputs("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
